// File: rtl/pipe_mux.sv
// Registered N-way select mux with valid/ready handshake and a two-entry skid buffer.
// The selected word is always registered; a stalled consumer never loses or repeats a word.
module pipe_mux #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned NUM_IN = 4,
    localparam int unsigned SEL_W = $clog2(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    flush,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_sel,
    output logic                    out_err,
    output logic                    out_valid,
    input  logic                    out_ready
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic             accept;
    logic             pop;
    logic             ld_main_in;
    logic             ld_main_skid;
    logic             ld_skid_in;

    logic [WIDTH-1:0] cap_data;
    logic             cap_err;

    logic [WIDTH-1:0] skid_data;
    logic [SEL_W-1:0] skid_sel;
    logic             skid_err;

    assign accept = in_valid & in_ready;
    assign pop    = out_valid & out_ready;

    // Select the addressed input; an out-of-range index yields an all-zero word and err.
    always_comb begin
        cap_data = '0;
        cap_err  = 1'b1;
        for (int unsigned k = 0; k < NUM_IN; k++) begin
            if (in_sel == SEL_W'(k)) begin
                cap_data = in_data[k*WIDTH +: WIDTH];
                cap_err  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            state     <= state_next;
            out_valid <= (state_next != EMPTY);
            in_ready  <= (state_next != FULL);
        end
    end

    // Occupancy transitions; flush overrides everything and drops any simultaneous accept.
    always_comb begin
        state_next   = state;
        ld_main_in   = 1'b0;
        ld_main_skid = 1'b0;
        ld_skid_in   = 1'b0;
        case (state)
            EMPTY: begin
                if (accept) begin
                    state_next = ONE;
                    ld_main_in = 1'b1;
                end
            end
            ONE: begin
                if (accept && !pop) begin
                    state_next = FULL;
                    ld_skid_in = 1'b1;
                end else if (!accept && pop) begin
                    state_next = EMPTY;
                end else if (accept && pop) begin
                    ld_main_in = 1'b1;
                end
            end
            FULL: begin
                if (pop) begin
                    state_next   = ONE;
                    ld_main_skid = 1'b1;
                end
            end
            default: state_next = EMPTY;
        endcase
        if (flush) begin
            state_next   = EMPTY;
            ld_main_in   = 1'b0;
            ld_main_skid = 1'b0;
            ld_skid_in   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data  <= '0;
            out_sel   <= '0;
            out_err   <= 1'b0;
            skid_data <= '0;
            skid_sel  <= '0;
            skid_err  <= 1'b0;
        end else begin
            if (ld_main_in) begin
                out_data <= cap_data;
                out_sel  <= in_sel;
                out_err  <= cap_err;
            end else if (ld_main_skid) begin
                out_data <= skid_data;
                out_sel  <= skid_sel;
                out_err  <= skid_err;
            end
            if (ld_skid_in) begin
                skid_data <= cap_data;
                skid_sel  <= in_sel;
                skid_err  <= cap_err;
            end
        end
    end

endmodule

// File: tb/tb_pipe_mux.sv
// Bench for pipe_mux: directed vector table plus scoreboard on a 4x32 instance,
// invalid-select on a 3x16 instance, and a randomized sweep on a 5x8 instance.
module tb_pipe_mux;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Instance A: WIDTH=32, NUM_IN=4
    logic [127:0] a_data;
    logic [1:0]   a_sel;
    logic         a_valid, a_flush, a_ordy;
    logic         a_in_ready, a_out_err, a_out_valid;
    logic [31:0]  a_out_data;
    logic [1:0]   a_out_sel;

    pipe_mux #(.WIDTH(32), .NUM_IN(4)) u_a (
        .clk(clk), .rst(rst), .in_data(a_data), .in_sel(a_sel), .in_valid(a_valid),
        .in_ready(a_in_ready), .flush(a_flush), .out_data(a_out_data), .out_sel(a_out_sel),
        .out_err(a_out_err), .out_valid(a_out_valid), .out_ready(a_ordy)
    );

    // Instance B: WIDTH=8, NUM_IN=5
    logic [39:0] b_data;
    logic [2:0]  b_sel;
    logic        b_valid, b_flush, b_ordy;
    logic        b_in_ready, b_out_err, b_out_valid;
    logic [7:0]  b_out_data;
    logic [2:0]  b_out_sel;

    pipe_mux #(.WIDTH(8), .NUM_IN(5)) u_b (
        .clk(clk), .rst(rst), .in_data(b_data), .in_sel(b_sel), .in_valid(b_valid),
        .in_ready(b_in_ready), .flush(b_flush), .out_data(b_out_data), .out_sel(b_out_sel),
        .out_err(b_out_err), .out_valid(b_out_valid), .out_ready(b_ordy)
    );

    // Instance C: WIDTH=16, NUM_IN=3
    logic [47:0] c_data;
    logic [1:0]  c_sel;
    logic        c_valid, c_flush, c_ordy;
    logic        c_in_ready, c_out_err, c_out_valid;
    logic [15:0] c_out_data;
    logic [1:0]  c_out_sel;

    pipe_mux #(.WIDTH(16), .NUM_IN(3)) u_c (
        .clk(clk), .rst(rst), .in_data(c_data), .in_sel(c_sel), .in_valid(c_valid),
        .in_ready(c_in_ready), .flush(c_flush), .out_data(c_out_data), .out_sel(c_out_sel),
        .out_err(c_out_err), .out_valid(c_out_valid), .out_ready(c_ordy)
    );

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  sel;
        logic        err;
    } a_exp_t;

    typedef struct packed {
        logic [7:0] data;
        logic [2:0] sel;
        logic       err;
    } b_exp_t;

    typedef struct {
        bit v;
        int sel;
        bit ordy;
        bit fl;
        bit e_ov;
        bit e_ir;
        int e_sel;
    } row_t;

    a_exp_t a_q[$];
    b_exp_t b_q[$];
    row_t   tbl[$];
    logic [31:0] a_word[4];

    initial begin
        a_exp_t ae;
        b_exp_t be;
        b_exp_t held;
        bit     hold;
        int     s;

        a_word[0] = 32'hAAAA_0000;
        a_word[1] = 32'hBBBB_0001;
        a_word[2] = 32'hCCCC_0002;
        a_word[3] = 32'hDDDD_0003;
        a_data = {a_word[3], a_word[2], a_word[1], a_word[0]};

        // v, sel, out_ready, flush | expected out_valid, in_ready, out_sel after the edge
        tbl.push_back('{1, 0, 1, 0, 1, 1, 0});
        tbl.push_back('{1, 1, 1, 0, 1, 1, 1});
        tbl.push_back('{1, 2, 1, 0, 1, 1, 2});
        tbl.push_back('{1, 3, 1, 0, 1, 1, 3});
        tbl.push_back('{0, 0, 1, 0, 0, 1, 0});
        tbl.push_back('{1, 1, 0, 0, 1, 1, 1});
        tbl.push_back('{1, 2, 0, 0, 1, 0, 1});
        tbl.push_back('{1, 3, 0, 0, 1, 0, 1});
        tbl.push_back('{0, 0, 1, 0, 1, 1, 2});
        tbl.push_back('{0, 0, 1, 0, 0, 1, 0});
        tbl.push_back('{1, 0, 0, 0, 1, 1, 0});
        tbl.push_back('{1, 3, 0, 0, 1, 0, 0});
        tbl.push_back('{1, 1, 1, 0, 1, 1, 3});
        tbl.push_back('{1, 1, 1, 0, 1, 1, 1});
        tbl.push_back('{0, 0, 1, 0, 0, 1, 0});
        tbl.push_back('{1, 2, 0, 0, 1, 1, 2});
        tbl.push_back('{1, 3, 0, 0, 1, 0, 2});
        tbl.push_back('{1, 0, 0, 1, 0, 1, 0});
        tbl.push_back('{0, 0, 1, 0, 0, 1, 0});
        tbl.push_back('{1, 1, 1, 1, 0, 1, 0});
        tbl.push_back('{1, 0, 1, 0, 1, 1, 0});
        tbl.push_back('{0, 0, 1, 0, 0, 1, 0});
        tbl.push_back('{1, 2, 1, 0, 1, 1, 2});
        tbl.push_back('{0, 0, 1, 1, 0, 1, 0});

        rst = 1'b1;
        a_sel = '0; a_valid = 1'b0; a_flush = 1'b0; a_ordy = 1'b0;
        b_data = '0; b_sel = '0; b_valid = 1'b0; b_flush = 1'b0; b_ordy = 1'b0;
        c_data = {16'h3333, 16'h2222, 16'h1111};
        c_sel = '0; c_valid = 1'b0; c_flush = 1'b0; c_ordy = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(a_out_valid), 64'(0));
        check("rst_in_ready", 64'(a_in_ready), 64'(1));
        check("rst_out_data", 64'(a_out_data), 64'(0));
        check("rst_out_sel", 64'(a_out_sel), 64'(0));
        check("rst_out_err", 64'(a_out_err), 64'(0));
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Directed vectors on instance A with the scoreboard running alongside
        foreach (tbl[i]) begin
            a_valid = tbl[i].v;
            a_sel   = 2'(tbl[i].sel);
            a_ordy  = tbl[i].ordy;
            a_flush = tbl[i].fl;
            if (a_out_valid && a_ordy) begin
                if (a_q.size() == 0) begin
                    check("a_sb_unexpected_pop", 64'(1), 64'(0));
                end else begin
                    ae = a_q.pop_front();
                    check("a_sb_data", 64'(a_out_data), 64'(ae.data));
                    check("a_sb_sel", 64'(a_out_sel), 64'(ae.sel));
                    check("a_sb_err", 64'(a_out_err), 64'(ae.err));
                end
            end
            if (a_flush) a_q.delete();
            else if (a_valid && a_in_ready) a_q.push_back('{data: a_word[tbl[i].sel], sel: a_sel, err: 1'b0});
            @(posedge clk);
            #1;
            check($sformatf("row%0d_out_valid", i), 64'(a_out_valid), 64'(tbl[i].e_ov));
            check($sformatf("row%0d_in_ready", i), 64'(a_in_ready), 64'(tbl[i].e_ir));
            if (tbl[i].e_ov) begin
                check($sformatf("row%0d_out_data", i), 64'(a_out_data), 64'(a_word[tbl[i].e_sel]));
                check($sformatf("row%0d_out_sel", i), 64'(a_out_sel), 64'(tbl[i].e_sel));
                check($sformatf("row%0d_out_err", i), 64'(a_out_err), 64'(0));
            end
        end
        check("a_sb_empty", 64'(a_q.size()), 64'(0));

        // Asynchronous reset while a word is held
        a_valid = 1'b1; a_sel = 2'd1; a_ordy = 1'b0; a_flush = 1'b0;
        @(posedge clk);
        #1;
        a_valid = 1'b0;
        check("pre_rst_out_valid", 64'(a_out_valid), 64'(1));
        check("pre_rst_out_data", 64'(a_out_data), 64'(a_word[1]));
        #2 rst = 1'b1;
        #1;
        check("async_rst_out_valid", 64'(a_out_valid), 64'(0));
        check("async_rst_in_ready", 64'(a_in_ready), 64'(1));
        check("async_rst_out_data", 64'(a_out_data), 64'(0));
        check("async_rst_out_sel", 64'(a_out_sel), 64'(0));
        #1 rst = 1'b0;
        a_q.delete();
        @(posedge clk);
        #1;
        check("post_rst_out_valid", 64'(a_out_valid), 64'(0));

        // Invalid select on the three-input instance
        c_valid = 1'b1; c_sel = 2'd3; c_ordy = 1'b1;
        @(posedge clk);
        #1;
        check("c_bad_out_valid", 64'(c_out_valid), 64'(1));
        check("c_bad_out_err", 64'(c_out_err), 64'(1));
        check("c_bad_out_data", 64'(c_out_data), 64'(0));
        check("c_bad_out_sel", 64'(c_out_sel), 64'(3));
        c_sel = 2'd2;
        @(posedge clk);
        #1;
        check("c_ok_out_err", 64'(c_out_err), 64'(0));
        check("c_ok_out_data", 64'(c_out_data), 64'(16'h3333));
        check("c_ok_out_sel", 64'(c_out_sel), 64'(2));
        c_valid = 1'b0;
        @(posedge clk);
        #1;
        check("c_drain_out_valid", 64'(c_out_valid), 64'(0));

        // Randomized sweep on the five-input byte instance
        hold = 1'b0;
        held = '0;
        for (int cyc = 0; cyc < 1000; cyc++) begin
            if (hold) begin
                check("b_hold_data", 64'(b_out_data), 64'(held.data));
                check("b_hold_sel", 64'(b_out_sel), 64'(held.sel));
                check("b_hold_err", 64'(b_out_err), 64'(held.err));
            end
            b_data  = 40'({$urandom(), $urandom()});
            s       = int'($urandom_range(0, 7));
            b_sel   = 3'(s);
            b_valid = ($urandom_range(0, 3) != 0);
            b_ordy  = ($urandom_range(0, 2) != 0);
            b_flush = ($urandom_range(0, 49) == 0);
            if (b_out_valid && b_ordy) begin
                if (b_q.size() == 0) begin
                    check("b_sb_unexpected_pop", 64'(1), 64'(0));
                end else begin
                    be = b_q.pop_front();
                    check("b_sb_data", 64'(b_out_data), 64'(be.data));
                    check("b_sb_sel", 64'(b_out_sel), 64'(be.sel));
                    check("b_sb_err", 64'(b_out_err), 64'(be.err));
                end
            end
            if (b_flush) begin
                b_q.delete();
            end else if (b_valid && b_in_ready) begin
                be.sel  = b_sel;
                be.err  = (s >= 5);
                be.data = (s < 5) ? b_data[s*8 +: 8] : 8'h00;
                b_q.push_back(be);
            end
            hold = b_out_valid && !b_ordy && !b_flush;
            held = '{data: b_out_data, sel: b_out_sel, err: b_out_err};
            @(posedge clk);
            #1;
        end

        // Drain whatever is left and confirm nothing remains
        b_valid = 1'b0; b_flush = 1'b0; b_ordy = 1'b1;
        for (int cyc = 0; cyc < 4; cyc++) begin
            if (b_out_valid) begin
                if (b_q.size() == 0) begin
                    check("b_drain_unexpected_pop", 64'(1), 64'(0));
                end else begin
                    be = b_q.pop_front();
                    check("b_drain_data", 64'(b_out_data), 64'(be.data));
                    check("b_drain_sel", 64'(b_out_sel), 64'(be.sel));
                end
            end
            @(posedge clk);
            #1;
        end
        check("b_sb_empty", 64'(b_q.size()), 64'(0));
        check("b_final_out_valid", 64'(b_out_valid), 64'(0));
        check("b_final_in_ready", 64'(b_in_ready), 64'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
